instr_dispatcher: RTL and testbench
===================================

INSTR_DISPATCHER -- requirements
Module: instr_dispatcher

Interface
REQ-001 SHALL have parameter LOG_DEPTH, default 3, meaning the instruction buffer holds 2^LOG_DEPTH entries.
REQ-002 SHALL have ports clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports queue_we  in  1  push strobe; queue_instr_type  in  2  instruction type; queue_instr  in  14  instruction payload bits.
REQ-004 SHALL have ports cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr  in  18 each  APU-resolved addresses and strides.
REQ-005 SHALL have ports program_complete  in  1  end-of-program pulse; queue_full  out  1  buffer full; overflow  out  1  sticky push-while-full error; bad_type  out  1  sticky loop-type-pushed error; done  out  1  one-cycle drain-complete pulse.
REQ-006 SHALL have ports ldst_valid  out  1; ldst_ready  in  1; ldst_instr  out  14; ldst_cache_addr  out  18; ldst_d_cache_addr  out  18.
REQ-007 SHALL have ports dma_valid  out  1; dma_ready  in  1; dma_instr  out  14; dma_cache_addr, dma_main_mem_addr, dma_d_cache_addr, dma_d_main_mem_addr  out  18 each.
REQ-008 SHALL have ports arith_valid  out  1; arith_ready  in  1; arith_instr  out  14.

Function
REQ-009 SHALL buffer pushed entries in a FIFO and issue strictly in order, at most one instruction per cycle.
REQ-010 SHALL accept a push when queue_we=1 and queue_full=0; an entry pushed in cycle N SHALL be visible at the head in cycle N+1.
REQ-011 SHALL drive queue_full from the registered occupancy (count == 2^LOG_DEPTH); a push while full SHALL be dropped and set overflow.
REQ-012 SHALL route the head by type: 0 LOAD_STORE -> ldst port, 1 RAM -> dma port, 2 ARITHMETIC -> arith port; exactly one valid SHALL be high when the FIFO is non-empty.
REQ-013 SHALL discard a type-3 (LOOP) push without storing it and set bad_type.
REQ-014 SHALL complete a transfer when valid&&ready; the head SHALL pop that same cycle, and the next entry SHALL present in cycle N+1.
REQ-015 SHALL hold valid high and the payload stable until ready; valid SHALL never drop without a handshake except on reset.
REQ-016 SHALL update count as push-only +1, pop-only -1, push+pop unchanged; a push+pop with the FIFO full SHALL drop the push (full is evaluated before the pop).
REQ-017 SHALL wrap the read/write pointers modulo 2^LOG_DEPTH; the count SHALL be LOG_DEPTH+1 bits wide.
REQ-018 SHALL implement the FSM IDLE, RUN, DRAIN, DONE: IDLE->RUN on an accepted push; RUN->DRAIN on program_complete; DRAIN->DONE when the FIFO is empty and no handshake is pending; DONE->IDLE unconditionally.
REQ-019 SHALL keep accepting pushes in DRAIN; in IDLE with program_complete and an empty FIFO, SHALL go IDLE->DONE directly.
REQ-020 SHALL assert done only in DONE, for exactly one cycle.
REQ-021 SHALL NOT clear overflow or bad_type except by reset.

Reset
REQ-022 SHALL, on reset=0 asynchronously: FSM=IDLE, pointers and count=0, all valid/done/queue_full/overflow/bad_type=0, all payload outputs=0.
REQ-023 SHALL discard buffered entries on reset assertion mid-operation; the first push after release SHALL be issued first.

Configuration
REQ-024 SHALL, with macro DISPATCH_PERF_COUNTERS_EN defined, add outputs issued_cnt (32) and stall_cnt (32): issued_cnt counts handshakes; stall_cnt counts cycles with a valid high and its ready low; both reset to 0 and saturate at all-ones.
REQ-025 SHALL, without DISPATCH_PERF_COUNTERS_EN, omit those ports and their logic entirely; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL import the INSTR_TYPE_* constants and the FSM state typedef from the shared core package; it SHALL NOT define local duplicates.
REQ-027 SHALL instantiate one sub-module, dispatch_fifo (storage, pointers, count, full/empty); routing, the FSM and the counters SHALL remain in instr_dispatcher.

Verification
REQ-028 Push LD/ST (cache_addr=0x100, d_cache_addr=4) with ldst_ready=1 -> ldst_valid high one cycle later, ldst_cache_addr=0x100, ldst_d_cache_addr=4, popped the same cycle.
REQ-029 Push RAM, ARITH, LD/ST back-to-back with all readies=1 -> dma, arith, ldst valids in three consecutive cycles, in order.
REQ-030 LOG_DEPTH=3, readies=0, push 9 entries -> queue_full after the 8th, 9th dropped, overflow=1, count=8; then ldst_ready=1 -> 8 issues with no loss.
REQ-031 Hold arith_ready=0 for 5 cycles with an ARITH head -> arith_valid and arith_instr stable for 5 cycles; stall_cnt=5 (macro defined).
REQ-032 Push 2 entries, pulse program_complete, then set readies=1 -> DRAIN, both issue, done pulses exactly once, FSM returns to IDLE.
REQ-033 Assert reset with 3 entries buffered -> all valids 0 immediately, count 0; after release, push type 3 -> not issued, bad_type=1.

Source files
------------

// File: rtl/instr_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// instr_dispatcher_pkg
// Shared core definitions for the instruction dispatcher:
//   - INSTR_TYPE_* encodings of the 2-bit instruction type field
//   - disp_state_t : dispatcher FSM state
//   - dispatch_entry_t : one buffered instruction with its resolved addresses
// -----------------------------------------------------------------------------
package instr_dispatcher_pkg;

    localparam int INSTR_W = 14;
    localparam int ADDR_W  = 18;

    localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd0;
    localparam logic [1:0] INSTR_TYPE_RAM        = 2'd1;
    localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd2;
    localparam logic [1:0] INSTR_TYPE_LOOP       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_t;

    typedef struct packed {
        logic [1:0]         instr_type;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  cache_addr;
        logic [ADDR_W-1:0]  main_mem_addr;
        logic [ADDR_W-1:0]  d_cache_addr;
        logic [ADDR_W-1:0]  d_main_mem_addr;
    } dispatch_entry_t;

endpackage

// File: rtl/dispatch_fifo.sv
// -----------------------------------------------------------------------------
// dispatch_fifo
// Circular instruction buffer of 2^LOG_DEPTH entries.
//   clk, reset      : clock, asynchronous active-low reset
//   push, wdata     : write request and entry; ignored while full
//   pop             : remove head; ignored while empty
//   rdata           : current head entry (valid only when !empty)
//   full, empty     : derived from the registered occupancy
//   count           : occupancy, LOG_DEPTH+1 bits
// Full is evaluated before the pop, so a push+pop while full drops the push.
// -----------------------------------------------------------------------------
module dispatch_fifo
    import instr_dispatcher_pkg::*;
#(
    parameter int LOG_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  dispatch_entry_t       wdata,
    output dispatch_entry_t       rdata,
    output logic                  full,
    output logic                  empty,
    output logic [LOG_DEPTH:0]    count
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    dispatch_entry_t        mem [DEPTH];
    logic [LOG_DEPTH-1:0]   wr_ptr;
    logic [LOG_DEPTH-1:0]   rd_ptr;
    logic                   push_ok;
    logic                   pop_ok;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly LOG_DEPTH bits wide, so they wrap by overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only observed once count covers it.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_dispatcher.sv
// -----------------------------------------------------------------------------
// instr_dispatcher
// Buffers APU instructions and issues them in order, one per cycle, to the
// load/store, DMA or arithmetic unit according to the instruction type.
//   clk, reset                      : clock, asynchronous active-low reset
//   queue_we/_instr_type/_instr     : push strobe, type, payload
//   cache_addr .. d_main_mem_addr   : resolved addresses/strides for the push
//   program_complete                : end-of-program pulse, starts draining
//   queue_full, overflow, bad_type  : full flag, sticky error flags
//   done                            : one-cycle pulse once drained
//   ldst_*, dma_*, arith_*          : valid/ready issue ports
//   issued_cnt, stall_cnt           : only with DISPATCH_PERF_COUNTERS_EN
//   dbg_state, dbg_count            : FSM state and buffer occupancy
// Handshake: a transfer completes in a cycle where valid && ready. Valid and
// payload are held stable until then; valid never drops without a transfer
// except on reset. Payload outputs are zero while their valid is low.
// Optional feature macro: DISPATCH_PERF_COUNTERS_EN.
// -----------------------------------------------------------------------------
module instr_dispatcher
    import instr_dispatcher_pkg::*;
#(
    parameter int LOG_DEPTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                queue_we,
    input  logic [1:0]          queue_instr_type,
    input  logic [INSTR_W-1:0]  queue_instr,
    input  logic [ADDR_W-1:0]   cache_addr,
    input  logic [ADDR_W-1:0]   main_mem_addr,
    input  logic [ADDR_W-1:0]   d_cache_addr,
    input  logic [ADDR_W-1:0]   d_main_mem_addr,
    input  logic                program_complete,
    output logic                queue_full,
    output logic                overflow,
    output logic                bad_type,
    output logic                done,
    output logic                ldst_valid,
    input  logic                ldst_ready,
    output logic [INSTR_W-1:0]  ldst_instr,
    output logic [ADDR_W-1:0]   ldst_cache_addr,
    output logic [ADDR_W-1:0]   ldst_d_cache_addr,
    output logic                dma_valid,
    input  logic                dma_ready,
    output logic [INSTR_W-1:0]  dma_instr,
    output logic [ADDR_W-1:0]   dma_cache_addr,
    output logic [ADDR_W-1:0]   dma_main_mem_addr,
    output logic [ADDR_W-1:0]   dma_d_cache_addr,
    output logic [ADDR_W-1:0]   dma_d_main_mem_addr,
    output logic                arith_valid,
    input  logic                arith_ready,
    output logic [INSTR_W-1:0]  arith_instr,
`ifdef DISPATCH_PERF_COUNTERS_EN
    output logic [31:0]         issued_cnt,
    output logic [31:0]         stall_cnt,
`endif
    output disp_state_t         dbg_state,
    output logic [LOG_DEPTH:0]  dbg_count
);

    dispatch_entry_t    push_entry;
    dispatch_entry_t    head;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LOG_DEPTH:0] fifo_count;
    logic               accepted_push;
    logic               head_ready;
    logic               handshake;
    disp_state_t        state;
    disp_state_t        state_nxt;

    // LOOP instructions are never stored.
    assign fifo_push     = queue_we && (queue_instr_type != INSTR_TYPE_LOOP);
    assign accepted_push = fifo_push && !fifo_full;
    assign push_entry    = '{instr_type:      queue_instr_type,
                             instr:           queue_instr,
                             cache_addr:      cache_addr,
                             main_mem_addr:   main_mem_addr,
                             d_cache_addr:    d_cache_addr,
                             d_main_mem_addr: d_main_mem_addr};

    dispatch_fifo #(.LOG_DEPTH(LOG_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (handshake),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign queue_full = fifo_full;
    assign dbg_count  = fifo_count;
    assign dbg_state  = state;

    // Route the head to exactly one port; everything stays zero when empty.
    always_comb begin
        ldst_valid          = 1'b0;
        ldst_instr          = '0;
        ldst_cache_addr     = '0;
        ldst_d_cache_addr   = '0;
        dma_valid           = 1'b0;
        dma_instr           = '0;
        dma_cache_addr      = '0;
        dma_main_mem_addr   = '0;
        dma_d_cache_addr    = '0;
        dma_d_main_mem_addr = '0;
        arith_valid         = 1'b0;
        arith_instr         = '0;
        head_ready          = 1'b0;
        if (!fifo_empty) begin
            case (head.instr_type)
                INSTR_TYPE_LOAD_STORE: begin
                    ldst_valid        = 1'b1;
                    ldst_instr        = head.instr;
                    ldst_cache_addr   = head.cache_addr;
                    ldst_d_cache_addr = head.d_cache_addr;
                    head_ready        = ldst_ready;
                end
                INSTR_TYPE_RAM: begin
                    dma_valid           = 1'b1;
                    dma_instr           = head.instr;
                    dma_cache_addr      = head.cache_addr;
                    dma_main_mem_addr   = head.main_mem_addr;
                    dma_d_cache_addr    = head.d_cache_addr;
                    dma_d_main_mem_addr = head.d_main_mem_addr;
                    head_ready          = dma_ready;
                end
                INSTR_TYPE_ARITHMETIC: begin
                    arith_valid = 1'b1;
                    arith_instr = head.instr;
                    head_ready  = arith_ready;
                end
                default: head_ready = 1'b0;
            endcase
        end
    end

    assign handshake = !fifo_empty && head_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            bad_type <= 1'b0;
        end else begin
            if (fifo_push && fifo_full)                       overflow <= 1'b1;
            if (queue_we && queue_instr_type == INSTR_TYPE_LOOP) bad_type <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accepted_push)                      state_nxt = ST_RUN;
                else if (program_complete && fifo_empty) state_nxt = ST_DONE;
            end
            ST_RUN: begin
                if (program_complete) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // An empty buffer has no valid, hence no handshake in flight.
                if (fifo_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic stalled;
    assign stalled = !fifo_empty && !head_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (handshake && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
            if (stalled && stall_cnt != '1)    stall_cnt  <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_dispatcher.sv
module tb_instr_dispatcher;
  import instr_dispatcher_pkg::*;

  localparam int LOG_DEPTH = 3;
  localparam int DEPTH     = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        queue_we = 0;
  logic [1:0]  queue_instr_type = 0;
  logic [13:0] queue_instr = 0;
  logic [17:0] cache_addr = 0, main_mem_addr = 0, d_cache_addr = 0, d_main_mem_addr = 0;
  logic        program_complete = 0;
  logic        queue_full, overflow, bad_type, done;
  logic        ldst_valid, ldst_ready = 0;
  logic [13:0] ldst_instr;
  logic [17:0] ldst_cache_addr, ldst_d_cache_addr;
  logic        dma_valid, dma_ready = 0;
  logic [13:0] dma_instr;
  logic [17:0] dma_cache_addr, dma_main_mem_addr, dma_d_cache_addr, dma_d_main_mem_addr;
  logic        arith_valid, arith_ready = 0;
  logic [13:0] arith_instr;
`ifdef DISPATCH_PERF_COUNTERS_EN
  logic [31:0] issued_cnt, stall_cnt;
`endif
  disp_state_t dbg_state;
  logic [LOG_DEPTH:0] dbg_count;

  instr_dispatcher #(.LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .queue_we(queue_we), .queue_instr_type(queue_instr_type), .queue_instr(queue_instr),
    .cache_addr(cache_addr), .main_mem_addr(main_mem_addr),
    .d_cache_addr(d_cache_addr), .d_main_mem_addr(d_main_mem_addr),
    .program_complete(program_complete),
    .queue_full(queue_full), .overflow(overflow), .bad_type(bad_type), .done(done),
    .ldst_valid(ldst_valid), .ldst_ready(ldst_ready), .ldst_instr(ldst_instr),
    .ldst_cache_addr(ldst_cache_addr), .ldst_d_cache_addr(ldst_d_cache_addr),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_instr(dma_instr),
    .dma_cache_addr(dma_cache_addr), .dma_main_mem_addr(dma_main_mem_addr),
    .dma_d_cache_addr(dma_d_cache_addr), .dma_d_main_mem_addr(dma_d_main_mem_addr),
    .arith_valid(arith_valid), .arith_ready(arith_ready), .arith_instr(arith_instr),
`ifdef DISPATCH_PERF_COUNTERS_EN
    .issued_cnt(issued_cnt), .stall_cnt(stall_cnt),
`endif
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- scoreboard / reference model ----------------
  // Entry layout: {type[87:86], instr[85:72], cache[71:54], mm[53:36], dcache[35:18], dmm[17:0]}
  logic [87:0] exp_q[$];
  bit          m_ovf, m_bad;
  longint      m_issued, m_stall;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ovf = 0; m_bad = 0; m_issued = 0; m_stall = 0;
  endtask

  task automatic compare_outputs();
    logic [87:0] h;
    logic [1:0]  t;
    bit ne, e_l, e_d, e_a;
    ne  = exp_q.size() > 0;
    h   = ne ? exp_q[0] : '0;
    t   = h[87:86];
    e_l = ne && t == 2'd0;
    e_d = ne && t == 2'd1;
    e_a = ne && t == 2'd2;
    check("ldst_valid", ldst_valid, e_l);
    check("dma_valid", dma_valid, e_d);
    check("arith_valid", arith_valid, e_a);
    check("ldst_instr", ldst_instr, e_l ? h[85:72] : 14'd0);
    check("ldst_cache_addr", ldst_cache_addr, e_l ? h[71:54] : 18'd0);
    check("ldst_d_cache_addr", ldst_d_cache_addr, e_l ? h[35:18] : 18'd0);
    check("dma_instr", dma_instr, e_d ? h[85:72] : 14'd0);
    check("dma_cache_addr", dma_cache_addr, e_d ? h[71:54] : 18'd0);
    check("dma_main_mem_addr", dma_main_mem_addr, e_d ? h[53:36] : 18'd0);
    check("dma_d_cache_addr", dma_d_cache_addr, e_d ? h[35:18] : 18'd0);
    check("dma_d_main_mem_addr", dma_d_main_mem_addr, e_d ? h[17:0] : 18'd0);
    check("arith_instr", arith_instr, e_a ? h[85:72] : 14'd0);
    check("queue_full", queue_full, exp_q.size() == DEPTH);
    check("dbg_count", dbg_count, exp_q.size());
    check("overflow", overflow, m_ovf);
    check("bad_type", bad_type, m_bad);
`ifdef DISPATCH_PERF_COUNTERS_EN
    check("issued_cnt", issued_cnt, m_issued);
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: checks outputs, drives one cycle of inputs,
  // advances the model across the rising edge, returns at the next falling edge.
  task automatic cycle(input bit we, input logic [1:0] ty, input logic [13:0] ins,
                       input logic [17:0] ca, input logic [17:0] mm,
                       input logic [17:0] dca, input logic [17:0] dmm,
                       input bit rl, input bit rd, input bit ra, input bit pc);
    logic [1:0] t;
    bit ne, rdy, full_pre;
    compare_outputs();
    queue_we = we; queue_instr_type = ty; queue_instr = ins;
    cache_addr = ca; main_mem_addr = mm; d_cache_addr = dca; d_main_mem_addr = dmm;
    ldst_ready = rl; dma_ready = rd; arith_ready = ra; program_complete = pc;
    ne       = exp_q.size() > 0;
    t        = ne ? exp_q[0][87:86] : 2'd0;
    rdy      = (t == 2'd0) ? rl : (t == 2'd1) ? rd : ra;
    full_pre = exp_q.size() == DEPTH;
    if (ne && rdy) begin
      void'(exp_q.pop_front());
      m_issued++;
    end
    if (ne && !rdy) m_stall++;
    if (we) begin
      if (ty == 2'd3)    m_bad = 1;
      else if (full_pre) m_ovf = 1;
      else               exp_q.push_back({ty, ins, ca, mm, dca, dmm});
    end
    @(posedge clk);
    @(negedge clk);
    queue_we = 0; program_complete = 0;
  endtask

  task automatic push(input logic [1:0] ty, input logic [13:0] ins, input logic [17:0] ca,
                      input logic [17:0] dca, input bit rl, input bit rd, input bit ra);
    cycle(1, ty, ins, ca, 18'h0, dca, 18'h0, rl, rd, ra, 0);
  endtask

  task automatic idle(input bit rl, input bit rd, input bit ra, input bit pc);
    cycle(0, 2'd0, 14'd0, 18'd0, 18'd0, 18'd0, 18'd0, rl, rd, ra, pc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    queue_we = 0; program_complete = 0; ldst_ready = 0; dma_ready = 0; arith_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  // ---------------- tests ----------------
  initial begin
    int ldst_seen, done_seen;
    bit saw_drain;
    model_clear();
    repeat (2) @(negedge clk);

    // Reset state (reset still asserted)
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_done", done, 0);
    compare_outputs();
    reset = 1;
    @(negedge clk);

    // Single LD/ST issue, popped in the cycle it is presented
    push(INSTR_TYPE_LOAD_STORE, 14'h15, 18'h100, 18'h4, 1, 1, 1);
    check("ldst1_valid", ldst_valid, 1);
    check("ldst1_cache", ldst_cache_addr, 18'h100);
    check("ldst1_dcache", ldst_d_cache_addr, 18'h4);
    check("ldst1_state", dbg_state, ST_RUN);
    idle(1, 1, 1, 0);
    check("ldst1_popped", dbg_count, 0);

    // RAM, ARITH, LD/ST back-to-back
    push(INSTR_TYPE_RAM, 14'h101, 18'h11, 18'h22, 1, 1, 1);
    check("b2b_dma", dma_valid, 1);
    push(INSTR_TYPE_ARITHMETIC, 14'h102, 18'h33, 18'h44, 1, 1, 1);
    check("b2b_arith", arith_valid, 1);
    push(INSTR_TYPE_LOAD_STORE, 14'h103, 18'h55, 18'h66, 1, 1, 1);
    check("b2b_ldst", ldst_valid, 1);
    idle(1, 1, 1, 0);
    check("b2b_empty", dbg_count, 0);

    // Fill to full, overflow on 9th, then drain without loss
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      push(INSTR_TYPE_LOAD_STORE, 14'(i + 1), 18'(i * 16), 18'(i), 0, 0, 0);
      if (i == 7) begin
        check("fill_full8", queue_full, 1);
        check("fill_noovf8", overflow, 0);
      end
    end
    check("fill_ovf", overflow, 1);
    check("fill_count", dbg_count, 8);
    ldst_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ldst_valid) ldst_seen++;
      idle(1, 0, 0, 0);
    end
    check("drain_issues", ldst_seen, 8);
    check("drain_empty", dbg_count, 0);

    // Stalled ARITH head stays put
    do_reset();
    @(negedge clk);
    push(INSTR_TYPE_ARITHMETIC, 14'h2A5, 18'h0, 18'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", arith_valid, 1);
      check("stall_instr", arith_instr, 14'h2A5);
      idle(0, 0, 0, 0);
    end
`ifdef DISPATCH_PERF_COUNTERS_EN
    check("stall_cnt5", stall_cnt, 5);
`endif
    idle(1, 1, 1, 0);

    // Drain sequence with program_complete
    do_reset();
    @(negedge clk);
    push(INSTR_TYPE_LOAD_STORE, 14'h7, 18'h1, 18'h2, 0, 0, 0);
    check("drn_run", dbg_state, ST_RUN);
    push(INSTR_TYPE_RAM, 14'h8, 18'h3, 18'h4, 0, 0, 0);
    idle(0, 0, 0, 1);
    check("drn_drain", dbg_state, ST_DRAIN);
    check("drn_count", dbg_count, 2);
    done_seen = 0; saw_drain = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_seen++;
      if (dbg_state == ST_DRAIN) saw_drain = 1;
      idle(1, 1, 1, 0);
    end
    check("drn_done_once", done_seen, 1);
    check("drn_saw_drain", saw_drain, 1);
    check("drn_idle", dbg_state, ST_IDLE);

    // IDLE with program_complete and empty buffer goes straight to DONE
    idle(0, 0, 0, 1);
    check("idle_done_state", dbg_state, ST_DONE);
    check("idle_done_pulse", done, 1);
    idle(0, 0, 0, 0);
    check("idle_done_back", dbg_state, ST_IDLE);

    // Reset mid-operation, then a LOOP push is rejected
    do_reset();
    @(negedge clk);
    push(INSTR_TYPE_RAM, 14'h31, 18'h1, 18'h1, 0, 0, 0);
    push(INSTR_TYPE_ARITHMETIC, 14'h32, 18'h2, 18'h2, 0, 0, 0);
    push(INSTR_TYPE_LOAD_STORE, 14'h33, 18'h3, 18'h3, 0, 0, 0);
    reset = 0;
    #1;
    check("mid_rst_dma", dma_valid, 0);
    check("mid_rst_arith", arith_valid, 0);
    check("mid_rst_ldst", ldst_valid, 0);
    check("mid_rst_count", dbg_count, 0);
    model_clear();
    @(negedge clk);
    reset = 1;
    push(INSTR_TYPE_LOOP, 14'h3F, 18'h9, 18'h9, 1, 1, 1);
    check("loop_bad", bad_type, 1);
    check("loop_not_stored", dbg_count, 0);
    push(INSTR_TYPE_LOAD_STORE, 14'h7, 18'h5, 18'h6, 0, 0, 0);
    check("first_after_rst", ldst_instr, 14'h7);
    idle(1, 1, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 55, 2'($urandom_range(0, 99) < 8 ? 3 : $urandom_range(0, 2)),
            14'($urandom), 18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 45, 0);
    end
    for (int i = 0; i < 12; i++) idle(1, 1, 1, 0);
    compare_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish before limit");
    $fatal(1, "timeout");
  end

endmodule
